// File: rtl/zbuffer_pixel_writer.sv
// Z-buffer write stage and framebuffer request queue, plus the per-frame depth clear sweep.
// Optional ZWRITER_STATS_EN adds pushed/dropped pixel counters on extra output ports.
module zbuffer_pixel_writer #(
    parameter int          SCREEN_WIDTH  = 320,
    parameter int          SCREEN_HEIGHT = 240,
    parameter int          FIFO_DEPTH    = 16,
    parameter logic [31:0] CLEAR_VALUE   = 32'd0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_write,
    input  logic [31:0] i_point,
    input  logic [31:0] i_zdata,
    input  logic [15:0] i_color,
    input  logic        i_clear,
    output logic        o_zbuffer_we,
    output logic [16:0] o_zbuffer_addr,
    output logic [31:0] o_zbuffer_data,
    output logic        o_fb_valid,
    input  logic        i_fb_ready,
    output logic [16:0] o_fb_addr,
    output logic [15:0] o_fb_data,
    output logic        o_busy,
    output logic        o_overflow
`ifdef ZWRITER_STATS_EN
    ,
    output logic [31:0] o_pix_count,
    output logic [31:0] o_drop_count
`endif
);

    localparam int NPIX = SCREEN_WIDTH * SCREEN_HEIGHT;
    localparam int PW   = $clog2(FIFO_DEPTH);

    typedef enum logic {S_IDLE, S_CLEAR} state_t;

    state_t        state_q;
    logic [16:0]   clr_q;
    logic          zwe_q, pix_vld_q, overflow_q;
    logic [16:0]   zaddr_q;
    logic [31:0]   zdata_q;

    logic [32:0]   fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;

    logic [15:0]   pt_x, pt_y;
    logic [16:0]   pix_addr;
    logic [32:0]   fifo_head;
    logic          in_range, accept, fifo_full, fifo_pop;
    logic          push_ok, drop_full, drop_clear;

    always_comb begin
        pt_x       = i_point[15:0];
        pt_y       = i_point[31:16];
        in_range   = (pt_x < 16'(SCREEN_WIDTH)) && (pt_y < 16'(SCREEN_HEIGHT));
        pix_addr   = 17'(pt_y) * 17'(SCREEN_WIDTH) + 17'(pt_x);
        accept     = (state_q == S_IDLE) && !i_clear && i_write && in_range;
        drop_clear = i_write && ((state_q == S_CLEAR) || i_clear);
        fifo_full  = (count_q == (PW+1)'(FIFO_DEPTH));
        fifo_pop   = o_fb_valid && i_fb_ready;
        // a pop in the same cycle frees the slot, so a full FIFO can still take the push
        push_ok    = accept && (!fifo_full || fifo_pop);
        drop_full  = accept && fifo_full && !fifo_pop;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= S_IDLE;
            clr_q      <= '0;
            zwe_q      <= 1'b0;
            pix_vld_q  <= 1'b0;
            zaddr_q    <= '0;
            zdata_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            zwe_q     <= 1'b0;
            pix_vld_q <= 1'b0;
            zaddr_q   <= '0;
            zdata_q   <= '0;
            if (i_clear) begin
                state_q <= S_CLEAR;
                clr_q   <= 17'd1;
                zwe_q   <= 1'b1;
                zdata_q <= CLEAR_VALUE;
            end else if (state_q == S_CLEAR) begin
                if (clr_q == 17'(NPIX)) begin
                    state_q <= S_IDLE;
                    clr_q   <= '0;
                end else begin
                    zwe_q   <= 1'b1;
                    zaddr_q <= clr_q;
                    zdata_q <= CLEAR_VALUE;
                    clr_q   <= clr_q + 17'd1;
                end
            end else if (accept) begin
                zwe_q     <= 1'b1;
                pix_vld_q <= 1'b1;
                zaddr_q   <= pix_addr;
                zdata_q   <= i_zdata;
            end

            if (i_clear)
                overflow_q <= drop_clear;
            else if (drop_clear || drop_full)
                overflow_q <= 1'b1;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok)
            wr_ptr_d = wr_ptr_q + 1'b1;
        if (fifo_pop)
            rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push_ok, fifo_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push_ok)
            fifo_mem[wr_ptr_q] <= {pix_addr, i_color};
    end

`ifdef ZWRITER_STATS_EN
    logic [31:0] pix_cnt_q, drop_cnt_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pix_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else if (i_clear) begin
            pix_cnt_q  <= '0;
            drop_cnt_q <= drop_clear ? 32'd1 : 32'd0;
        end else begin
            if (push_ok && (pix_cnt_q != 32'hFFFF_FFFF))
                pix_cnt_q <= pix_cnt_q + 32'd1;
            if ((drop_clear || drop_full) && (drop_cnt_q != 32'hFFFF_FFFF))
                drop_cnt_q <= drop_cnt_q + 32'd1;
        end
    end

    assign o_pix_count  = pix_cnt_q;
    assign o_drop_count = drop_cnt_q;
`endif

    assign fifo_head      = fifo_mem[rd_ptr_q];
    assign o_fb_valid     = (count_q != '0);
    assign o_fb_addr      = o_fb_valid ? fifo_head[32:16] : '0;
    assign o_fb_data      = o_fb_valid ? fifo_head[15:0] : '0;
    assign o_zbuffer_we   = zwe_q;
    assign o_zbuffer_addr = zaddr_q;
    assign o_zbuffer_data = zdata_q;
    assign o_overflow     = overflow_q;
    assign o_busy         = (state_q == S_CLEAR) || o_fb_valid || pix_vld_q;

endmodule

// File: tb/tb_zbuffer_pixel_writer.sv
// Bench for zbuffer_pixel_writer: vector table for the pixel path, scoreboard queue for
// framebuffer requests, hand-written sequences for overflow, clear sweep and reset abort.
module tb_zbuffer_pixel_writer;

    logic        clk;
    logic        rst;
    logic        i_write;
    logic [31:0] i_point;
    logic [31:0] i_zdata;
    logic [15:0] i_color;
    logic        i_clear;
    logic        o_zbuffer_we;
    logic [16:0] o_zbuffer_addr;
    logic [31:0] o_zbuffer_data;
    logic        o_fb_valid;
    logic        i_fb_ready;
    logic [16:0] o_fb_addr;
    logic [15:0] o_fb_data;
    logic        o_busy;
    logic        o_overflow;

    zbuffer_pixel_writer dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_write        (i_write),
        .i_point        (i_point),
        .i_zdata        (i_zdata),
        .i_color        (i_color),
        .i_clear        (i_clear),
        .o_zbuffer_we   (o_zbuffer_we),
        .o_zbuffer_addr (o_zbuffer_addr),
        .o_zbuffer_data (o_zbuffer_data),
        .o_fb_valid     (o_fb_valid),
        .i_fb_ready     (i_fb_ready),
        .o_fb_addr      (o_fb_addr),
        .o_fb_data      (o_fb_data),
        .o_busy         (o_busy),
        .o_overflow     (o_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] y;
        logic [15:0] x;
        logic [31:0] z;
        logic [15:0] color;
        logic        exp_we;
        logic [16:0] exp_addr;
    } vec_t;

    localparam int NV = 7;
    vec_t        vecs [NV];
    logic [32:0] sb_q [$];
    logic [32:0] mon_exp;
    int          tests = 0;
    int          fails = 0;
    int          pop_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_px(input logic [15:0] y, input logic [15:0] x,
                            input logic [31:0] z, input logic [15:0] c);
        i_write = 1'b1;
        i_point = {y, x};
        i_zdata = z;
        i_color = c;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_we"},       o_zbuffer_we,   0);
        check({tag, "_zaddr"},    o_zbuffer_addr, 0);
        check({tag, "_zdata"},    o_zbuffer_data, 0);
        check({tag, "_fb_valid"}, o_fb_valid,     0);
        check({tag, "_fb_addr"},  o_fb_addr,      0);
        check({tag, "_fb_data"},  o_fb_data,      0);
        check({tag, "_busy"},     o_busy,         0);
        check({tag, "_overflow"}, o_overflow,     0);
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        check({tag, "_drain_in_time"}, (n < 200), 1);
        check({tag, "_fb_valid_after"}, o_fb_valid, 0);
    endtask

    // scoreboard side: every handshake must match the oldest expected request
    always @(negedge clk) begin
        if (!rst && o_fb_valid && i_fb_ready) begin
            check("fb_pop_expected", (sb_q.size() != 0), 1);
            if (sb_q.size() != 0) begin
                mon_exp = sb_q.pop_front();
                check("fb_addr", o_fb_addr, mon_exp[32:16]);
                check("fb_data", o_fb_data, mon_exp[15:0]);
                pop_cnt++;
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        rst = 1'b1; i_write = 1'b0; i_point = '0; i_zdata = '0;
        i_color = '0; i_clear = 1'b0; i_fb_ready = 1'b0;

        vecs[0] = '{16'd2,   16'd5,   32'h0001_8000, 16'hF81F, 1'b1, 17'd645};
        vecs[1] = '{16'd0,   16'd0,   32'h0000_0001, 16'h07E0, 1'b1, 17'd0};
        vecs[2] = '{16'd239, 16'd319, 32'hFFFF_FFFF, 16'h001F, 1'b1, 17'd76799};
        vecs[3] = '{16'd240, 16'd0,   32'h1234_5678, 16'hAAAA, 1'b0, 17'd0};
        vecs[4] = '{16'd0,   16'd320, 32'h8765_4321, 16'h5555, 1'b0, 17'd0};
        vecs[5] = '{16'd1,   16'd0,   32'h0002_0000, 16'h1234, 1'b1, 17'd320};
        vecs[6] = '{16'd100, 16'd200, 32'h0000_4000, 16'hBEEF, 1'b1, 17'd32200};

        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        i_fb_ready = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(posedge clk); #1;
            drive_px(vecs[i].y, vecs[i].x, vecs[i].z, vecs[i].color);
            if (vecs[i].exp_we)
                sb_q.push_back({vecs[i].exp_addr, vecs[i].color});
            @(posedge clk); #1;
            i_write = 1'b0;
            check($sformatf("vec%0d_we", i), o_zbuffer_we, vecs[i].exp_we);
            check($sformatf("vec%0d_fb_valid", i), o_fb_valid, vecs[i].exp_we);
            check($sformatf("vec%0d_overflow", i), o_overflow, 0);
            if (vecs[i].exp_we) begin
                check($sformatf("vec%0d_zaddr", i), o_zbuffer_addr, vecs[i].exp_addr);
                check($sformatf("vec%0d_zdata", i), o_zbuffer_data, vecs[i].z);
            end
        end
        wait_drain("table");

        // 17 writes into a stalled 16-entry queue
        i_fb_ready = 1'b0;
        pop_cnt = 0;
        @(posedge clk); #1;
        for (int k = 0; k < 17; k++) begin
            drive_px(16'd3, 16'(k), 32'h0000_0100 + 32'(k), 16'h4000 + 16'(k));
            if (k < 16)
                sb_q.push_back({17'(960 + k), 16'h4000 + 16'(k)});
            @(posedge clk); #1;
            check($sformatf("ovf_we%0d", k), o_zbuffer_we, 1);
            check($sformatf("ovf_zaddr%0d", k), o_zbuffer_addr, 17'(960 + k));
            check($sformatf("ovf_zdata%0d", k), o_zbuffer_data, 32'h0000_0100 + 32'(k));
            if (k == 15)
                check("ovf_not_yet", o_overflow, 0);
        end
        i_write = 1'b0;
        check("ovf_set", o_overflow, 1);
        check("ovf_fb_valid", o_fb_valid, 1);
        @(posedge clk); #1;
        check("ovf_head_held", o_fb_addr, 17'd960);
        check("ovf_busy", o_busy, 1);
        i_fb_ready = 1'b1;
        wait_drain("ovf");
        check("ovf_pop_count", pop_cnt, 16);

        // clear sweep with a pixel strobe at sweep cycle 100
        @(posedge clk); #1;
        i_clear = 1'b1;
        @(posedge clk); #1;
        i_clear = 1'b0;
        check("clr_ovf_cleared", o_overflow, 0);
        check("clr_first_we", o_zbuffer_we, 1);
        check("clr_first_addr", o_zbuffer_addr, 0);
        bad = 0;
        for (int k = 1; k < 76800; k++) begin
            @(posedge clk); #1;
            if (!(o_zbuffer_we === 1'b1 && o_zbuffer_addr === 17'(k) &&
                  o_zbuffer_data === 32'd0 && o_busy === 1'b1))
                bad++;
            if (k == 100)
                drive_px(16'd5, 16'd5, 32'h0003_0000, 16'hCAFE);
            if (k == 101)
                i_write = 1'b0;
        end
        check("clr_sweep_bad_cycles", bad, 0);
        check("clr_drop_overflow", o_overflow, 1);
        @(posedge clk); #1;
        check("clr_done_we", o_zbuffer_we, 0);
        check("clr_done_busy", o_busy, 0);
        check("clr_done_fb_valid", o_fb_valid, 0);

        // reset mid-sweep with queued entries
        i_fb_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive_px(16'd1, 16'(k), 32'h10, 16'h00FF);
            @(posedge clk); #1;
        end
        i_write = 1'b0;
        check("abort_queued", o_fb_valid, 1);
        i_clear = 1'b1;
        @(posedge clk); #1;
        i_clear = 1'b0;
        for (int k = 1; k <= 5000; k++) begin
            @(posedge clk); #1;
        end
        check("abort_at_5000", o_zbuffer_addr, 17'd5000);
        #1 rst = 1'b1;
        #1;
        check_all_zero("abort");
        @(posedge clk); #1;
        rst = 1'b0;
        sb_q.delete();
        @(posedge clk); #1;
        check("abort_idle_we", o_zbuffer_we, 0);
        check("abort_idle_busy", o_busy, 0);

        // full queue, pop and push in the same cycle
        pop_cnt = 0;
        for (int k = 0; k < 16; k++) begin
            drive_px(16'd7, 16'(10 + k), 32'h20 + 32'(k), 16'h8000 + 16'(k));
            sb_q.push_back({17'(2240 + 10 + k), 16'h8000 + 16'(k)});
            @(posedge clk); #1;
        end
        drive_px(16'd7, 16'd50, 32'h0005_0000, 16'h9999);
        sb_q.push_back({17'd2290, 16'h9999});
        i_fb_ready = 1'b1;
        @(posedge clk); #1;
        i_write = 1'b0;
        i_fb_ready = 1'b0;
        check("full_pp_overflow", o_overflow, 0);
        check("full_pp_we", o_zbuffer_we, 1);
        check("full_pp_zaddr", o_zbuffer_addr, 17'd2290);
        check("full_pp_one_pop", pop_cnt, 1);
        i_fb_ready = 1'b1;
        wait_drain("full_pp");
        check("full_pp_pop_count", pop_cnt, 17);
        check("full_pp_overflow_end", o_overflow, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
